mem_port_arbiter: RTL and testbench

- Shares the single unified memory port between the IF stage (instruction fetch) and the MEM stage (LWD/SWD) of the 16-bit pipelined CPU.
- Each access takes a fixed multi-cycle latency. The block sequences one access at a time and produces the stall signals that the hazard logic uses to freeze the pipeline.
- The MEM stage has priority over IF. A starvation counter prevents IF from being locked out indefinitely.

---
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter for the unified memory port shared by the IF and MEM pipeline stages.
// Sequences one fixed-latency access at a time; MEM has priority, bounded by a starvation counter.
module mem_port_arbiter #(
    parameter int unsigned WORD_SIZE    = 16,
    parameter int unsigned MEM_LATENCY  = 2,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 if_req,
    input  logic [WORD_SIZE-1:0] if_addr,
    output logic [WORD_SIZE-1:0] if_data,
    output logic                 if_ready,
    input  logic                 mem_req,
    input  logic                 mem_we,
    input  logic [WORD_SIZE-1:0] mem_addr,
    input  logic [WORD_SIZE-1:0] mem_wdata,
    output logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 mem_ready,
    output logic                 stall_if,
    output logic                 stall_mem,
    output logic                 ram_read,
    output logic                 ram_write,
    output logic [WORD_SIZE-1:0] ram_addr,
    output logic [WORD_SIZE-1:0] ram_wdata,
    input  logic [WORD_SIZE-1:0] ram_rdata,
    output logic                 busy
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned STV_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [STV_W-1:0]     starve_q, starve_d;
    logic                 owner_mem_q, owner_mem_d;
    logic                 ram_read_d, ram_write_d;
    logic [WORD_SIZE-1:0] ram_addr_d, ram_wdata_d;
    logic [WORD_SIZE-1:0] if_data_d, mem_rdata_d;
    logic                 if_ready_d, mem_ready_d, busy_d;
    logic                 grant_if;

    // Stall the stage until its completion pulse arrives
    assign stall_if  = if_req  & ~if_ready;
    assign stall_mem = mem_req & ~mem_ready;

    // IF wins when MEM is absent or IF has waited through STARVE_LIMIT MEM grants
    assign grant_if = if_req & (~mem_req | (starve_q == STV_W'(STARVE_LIMIT)));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        owner_mem_d = owner_mem_q;
        ram_read_d  = ram_read;
        ram_write_d = ram_write;
        ram_addr_d  = ram_addr;
        ram_wdata_d = ram_wdata;
        if_data_d   = if_data;
        mem_rdata_d = mem_rdata;
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!if_req) begin
                    starve_d = '0;
                end
                if (grant_if) begin
                    owner_mem_d = 1'b0;
                    ram_read_d  = 1'b1;
                    ram_write_d = 1'b0;
                    ram_addr_d  = if_addr;
                    starve_d    = '0;
                    cnt_d       = CNT_W'(MEM_LATENCY - 1);
                    state_d     = ACCESS;
                end else if (mem_req) begin
                    owner_mem_d = 1'b1;
                    ram_read_d  = ~mem_we;
                    ram_write_d = mem_we;
                    ram_addr_d  = mem_addr;
                    ram_wdata_d = mem_wdata;
                    if (if_req && (starve_q != {STV_W{1'b1}})) begin
                        starve_d = starve_q + STV_W'(1);
                    end
                    cnt_d       = CNT_W'(MEM_LATENCY - 1);
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    if (ram_read) begin
                        if (owner_mem_q) mem_rdata_d = ram_rdata;
                        else             if_data_d   = ram_rdata;
                    end
                    ram_read_d  = 1'b0;
                    ram_write_d = 1'b0;
                    mem_ready_d = owner_mem_q;
                    if_ready_d  = ~owner_mem_q;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                // Requests are ignored here so a still-held request is not regranted
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            starve_q    <= '0;
            owner_mem_q <= 1'b0;
            ram_read    <= 1'b0;
            ram_write   <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            if_data     <= '0;
            mem_rdata   <= '0;
            if_ready    <= 1'b0;
            mem_ready   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            owner_mem_q <= owner_mem_d;
            ram_read    <= ram_read_d;
            ram_write   <= ram_write_d;
            ram_addr    <= ram_addr_d;
            ram_wdata   <= ram_wdata_d;
            if_data     <= if_data_d;
            mem_rdata   <= mem_rdata_d;
            if_ready    <= if_ready_d;
            mem_ready   <= mem_ready_d;
            busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (latency 2 and 1) against a timeline-based reference model.
module tb_mem_port_arbiter;

    localparam int unsigned W  = 16;
    localparam int          SL = 3;

    logic         clk;
    logic         reset_n;
    logic         if_req, mem_req, mem_we;
    logic [W-1:0] if_addr, mem_addr, mem_wdata, ram_rdata;

    logic [1:0][W-1:0] if_data_o, mem_rdata_o, ram_addr_o, ram_wdata_o;
    logic [1:0]        if_ready_o, mem_ready_o, stall_if_o, stall_mem_o;
    logic [1:0]        ram_read_o, ram_write_o, busy_o;

    mem_port_arbiter #(.WORD_SIZE(W), .MEM_LATENCY(2), .STARVE_LIMIT(SL)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_data(if_data_o[0]), .if_ready(if_ready_o[0]),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata_o[0]), .mem_ready(mem_ready_o[0]),
        .stall_if(stall_if_o[0]), .stall_mem(stall_mem_o[0]),
        .ram_read(ram_read_o[0]), .ram_write(ram_write_o[0]), .ram_addr(ram_addr_o[0]),
        .ram_wdata(ram_wdata_o[0]), .ram_rdata(ram_rdata), .busy(busy_o[0])
    );

    mem_port_arbiter #(.WORD_SIZE(W), .MEM_LATENCY(1), .STARVE_LIMIT(SL)) u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_data(if_data_o[1]), .if_ready(if_ready_o[1]),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata_o[1]), .mem_ready(mem_ready_o[1]),
        .stall_if(stall_if_o[1]), .stall_mem(stall_mem_o[1]),
        .ram_read(ram_read_o[1]), .ram_write(ram_write_o[1]), .ram_addr(ram_addr_o[1]),
        .ram_wdata(ram_wdata_o[1]), .ram_rdata(ram_rdata), .busy(busy_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;
    int cyc    = 0;

    // Reference model: each access is a transaction granted at cycle t0; every output
    // follows from where the current cycle sits relative to t0 on the access timeline.
    bit     m_txn   [2];
    int     m_t0    [2];
    bit     m_own   [2];
    bit     m_we    [2];
    logic [W-1:0] m_addr [2], m_wdata [2], m_ifd [2], m_memd [2];
    int     m_starve[2];

    function automatic int lat(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic bit m_active(input int k);
        return m_txn[k] && (cyc >= m_t0[k] + 1) && (cyc <= m_t0[k] + lat(k));
    endfunction

    function automatic bit m_ready(input int k);
        return m_txn[k] && (cyc == m_t0[k] + lat(k) + 1);
    endfunction

    function automatic bit m_busy(input int k);
        return m_txn[k] && (cyc >= m_t0[k] + 1) && (cyc <= m_t0[k] + lat(k) + 1);
    endfunction

    function automatic bit m_idle(input int k);
        return !m_txn[k] || (cyc >= m_t0[k] + lat(k) + 2);
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            bit rdy_if, rdy_mem;
            rdy_if  = m_ready(k) && !m_own[k];
            rdy_mem = m_ready(k) && m_own[k];
            check($sformatf("ram_read%0d", k),  W'(ram_read_o[k]),  W'(m_active(k) && !m_we[k]));
            check($sformatf("ram_write%0d", k), W'(ram_write_o[k]), W'(m_active(k) && m_we[k]));
            check($sformatf("ram_addr%0d", k),  ram_addr_o[k],  m_addr[k]);
            check($sformatf("ram_wdata%0d", k), ram_wdata_o[k], m_wdata[k]);
            check($sformatf("if_ready%0d", k),  W'(if_ready_o[k]),  W'(rdy_if));
            check($sformatf("mem_ready%0d", k), W'(mem_ready_o[k]), W'(rdy_mem));
            check($sformatf("if_data%0d", k),   if_data_o[k],   m_ifd[k]);
            check($sformatf("mem_rdata%0d", k), mem_rdata_o[k], m_memd[k]);
            check($sformatf("busy%0d", k),      W'(busy_o[k]),  W'(m_busy(k)));
            check($sformatf("stall_if%0d", k),  W'(stall_if_o[k]),  W'(if_req && !rdy_if));
            check($sformatf("stall_mem%0d", k), W'(stall_mem_o[k]), W'(mem_req && !rdy_mem));
        end
    endtask

    // Advance the model across the clock edge that ends cycle `cyc`
    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) begin
                m_txn[k] = 0; m_own[k] = 0; m_we[k] = 0; m_starve[k] = 0;
                m_addr[k] = '0; m_wdata[k] = '0; m_ifd[k] = '0; m_memd[k] = '0;
            end else begin
                if (m_txn[k] && (cyc == m_t0[k] + lat(k)) && !m_we[k]) begin
                    if (m_own[k]) m_memd[k] = ram_rdata;
                    else          m_ifd[k]  = ram_rdata;
                end
                if (m_idle(k)) begin
                    if (!if_req) m_starve[k] = 0;
                    if (if_req && (!mem_req || m_starve[k] == SL)) begin
                        m_txn[k] = 1; m_t0[k] = cyc; m_own[k] = 0; m_we[k] = 0;
                        m_addr[k] = if_addr; m_starve[k] = 0;
                    end else if (mem_req) begin
                        m_txn[k] = 1; m_t0[k] = cyc; m_own[k] = 1; m_we[k] = mem_we;
                        m_addr[k] = mem_addr; m_wdata[k] = mem_wdata;
                        if (if_req) m_starve[k] = (m_starve[k] < 7) ? m_starve[k] + 1 : 7;
                    end else begin
                        m_txn[k] = 0;
                    end
                end
            end
        end
        cyc++;
    endtask

    task automatic tick_check();
        @(negedge clk);
        if (chk_en) check_all();
    endtask

    task automatic tick_edge();
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        reset_n = 1'b0; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        if_addr = '0; mem_addr = '0; mem_wdata = '0; ram_rdata = '0;
        tick_check(); tick_edge();
        tick_check(); tick_edge();
        chk_en = 1;

        // IF read alone
        reset_n = 1'b1; ram_rdata = 16'hA5A5;
        for (int i = 0; i <= 4; i++) begin
            if_req = (i <= 3); if_addr = 16'h0010;
            tick_check();
            if (i <= 2) check("t1_stall_if", W'(stall_if_o[0]), W'(1));
            if (i == 1 || i == 2) begin
                check("t1_ram_read", W'(ram_read_o[0]), W'(1));
                check("t1_ram_addr", ram_addr_o[0], 16'h0010);
            end
            if (i == 3) begin
                check("t1_if_ready", W'(if_ready_o[0]), W'(1));
                check("t1_if_data", if_data_o[0], 16'hA5A5);
            end
            tick_edge();
        end

        // Simultaneous requests: MEM write first, then IF
        for (int i = 0; i <= 8; i++) begin
            if (i == 0) begin
                if_req = 1'b1; if_addr = 16'h0030;
                mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'h0020; mem_wdata = 16'h1234;
            end
            if (i == 4) mem_req = 1'b0;
            if (i == 8) if_req = 1'b0;
            tick_check();
            if (i == 1 || i == 2) begin
                check("t2_ram_write", W'(ram_write_o[0]), W'(1));
                check("t2_ram_wdata", ram_wdata_o[0], 16'h1234);
            end
            if (i == 3) check("t2_mem_ready", W'(mem_ready_o[0]), W'(1));
            if (i == 5) check("t2_if_addr", ram_addr_o[0], 16'h0030);
            if (i == 7) check("t2_if_ready", W'(if_ready_o[0]), W'(1));
            tick_edge();
        end

        // Starvation: three MEM loads, one IF fetch, then MEM again
        mem_we = 1'b0;
        for (int i = 0; i <= 20; i++) begin
            if (i == 1) begin
                mem_req = 1'b1; mem_addr = 16'h0100; if_req = 1'b1; if_addr = 16'h0200;
            end
            if (i == 20) begin
                mem_req = 1'b0; if_req = 1'b0;
            end
            tick_check();
            if (i == 2 || i == 6 || i == 10 || i == 18) check("t3_mem_grant", ram_addr_o[0], 16'h0100);
            if (i == 14) check("t3_if_grant", ram_addr_o[0], 16'h0200);
            if (i == 10) check("t3_starve_sat", W'(u_dut.starve_q), W'(SL));
            if (i == 14) check("t3_starve_clr", W'(u_dut.starve_q), W'(0));
            tick_edge();
        end

        // Reset in the first ACCESS cycle aborts the read
        ram_rdata = 16'h5A5A;
        for (int i = 0; i <= 8; i++) begin
            if (i == 1) begin
                if_req = 1'b1; if_addr = 16'h0050;
            end
            reset_n = (i != 2);
            if (i == 7) if_req = 1'b0;
            tick_check();
            if (i == 3) begin
                check("t4_busy", W'(busy_o[0]), W'(0));
                check("t4_ram_read", W'(ram_read_o[0]), W'(0));
                check("t4_ready", W'({if_ready_o[0], mem_ready_o[0]}), W'(0));
            end
            if (i == 6) begin
                check("t4_if_ready", W'(if_ready_o[0]), W'(1));
                check("t4_if_data", if_data_o[0], 16'h5A5A);
            end
            tick_edge();
        end

        // MEM request dropped mid-access still completes
        ram_rdata = 16'h00FF;
        for (int i = 0; i <= 5; i++) begin
            if (i == 0) begin
                mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h0040;
            end
            if (i == 2) mem_req = 1'b0;
            tick_check();
            if (i == 3) begin
                check("t5_mem_ready", W'(mem_ready_o[0]), W'(1));
                check("t5_mem_rdata", mem_rdata_o[0], 16'h00FF);
            end
            if (i == 4 || i == 5) check("t5_no_regrant", W'(busy_o[0]), W'(0));
            tick_edge();
        end

        // Latency 1 instance: back-to-back fetches
        for (int i = 0; i <= 6; i++) begin
            if_req = (i <= 5);
            if_addr = (i >= 3) ? 16'h0001 : 16'h0000;
            tick_check();
            check("t6_ram_read", W'(ram_read_o[1]), W'(i == 1 || i == 4));
            if (i == 2 || i == 5) check("t6_if_ready", W'(if_ready_o[1]), W'(1));
            if (i == 4) check("t6_ram_addr", ram_addr_o[1], 16'h0001);
            tick_edge();
        end

        // Random traffic, including occasional resets
        for (int i = 0; i < 500; i++) begin
            reset_n   = ($urandom_range(0, 63) != 0);
            if_req    = ($urandom_range(0, 3) != 0);
            mem_req   = ($urandom_range(0, 3) != 0);
            mem_we    = $urandom_range(0, 1) == 1;
            if_addr   = W'($urandom);
            mem_addr  = W'($urandom);
            mem_wdata = W'($urandom);
            ram_rdata = W'($urandom);
            tick_check();
            tick_edge();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
